// File: rtl/jag_pad_scanner.sv
// Host-side Jaguar joypad matrix scanner: walks the four column lines, samples the
// synchronised rows, and debounces the 21-bit button vector across whole frames.
//
// state  | meaning
// IDLE   | all columns released, idle timer counts down while enabled
// DRIVE  | one column held low for SETTLE_CYCLES, rows captured on the last cycle
// GAP    | one released cycle between columns (break-before-make)
// COMMIT | frame complete: debounce update, frame_done pulse
module jag_pad_scanner #(
    parameter int SETTLE_CYCLES = 64,
    parameter int IDLE_CYCLES   = 1024,
    parameter int DEBOUNCE      = 2
) (
    input  logic        sys_clk,
    input  logic        xresetl,
    input  logic        enable,
    output logic [3:0]  col_n_o,
    input  logic [5:0]  row_n_i,
    output logic [20:0] buttons,
    output logic        frame_done,
    output logic        busy
);

    localparam int CNT_MAX = (IDLE_CYCLES > SETTLE_CYCLES) ? IDLE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int STB_W   = $clog2(DEBOUNCE + 1);

    localparam logic [CNT_W-1:0] IDLE_LOAD   = CNT_W'(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_MAX     = STB_W'(DEBOUNCE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_GAP,
        ST_COMMIT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         col_q, col_d;
    logic [3:0]         col_n_q, col_n_d;
    logic [20:0]        shadow_q, shadow_d;
    logic [20:0]        prev_q, prev_d;
    logic [STB_W-1:0]   stable_q, stable_d;
    logic [20:0]        buttons_q, buttons_d;
    logic [5:0]         row_s1_q, row_s2_q;

    always_ff @(posedge sys_clk or negedge xresetl) begin
        if (!xresetl) begin
            row_s1_q <= 6'b111111;
            row_s2_q <= 6'b111111;
        end else begin
            row_s1_q <= row_n_i;
            row_s2_q <= row_s1_q;
        end
    end

    always_ff @(posedge sys_clk or negedge xresetl) begin
        if (!xresetl) begin
            state_q   <= ST_IDLE;
            cnt_q     <= IDLE_LOAD;
            col_q     <= 2'd0;
            col_n_q   <= 4'b1111;
            shadow_q  <= '0;
            prev_q    <= '0;
            stable_q  <= '0;
            buttons_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            col_q     <= col_d;
            col_n_q   <= col_n_d;
            shadow_q  <= shadow_d;
            prev_q    <= prev_d;
            stable_q  <= stable_d;
            buttons_q <= buttons_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        col_d     = col_q;
        shadow_d  = shadow_q;
        prev_d    = prev_q;
        stable_d  = stable_q;
        buttons_d = buttons_q;

        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = ST_DRIVE;
                        col_d   = 2'd0;
                        cnt_d   = SETTLE_LOAD;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_DRIVE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    cnt_d   = IDLE_LOAD;
                end else if (cnt_q == '0) begin
                    // Row 1 only carries a button on the last column.
                    unique case (col_q)
                        2'd0: shadow_d[4:0]   = ~row_s2_q[5:1];
                        2'd1: shadow_d[9:5]   = ~row_s2_q[5:1];
                        2'd2: shadow_d[14:10] = ~row_s2_q[5:1];
                        2'd3: shadow_d[20:15] = ~row_s2_q;
                        default: ;
                    endcase
                    state_d = (col_q == 2'd3) ? ST_COMMIT : ST_GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    cnt_d   = IDLE_LOAD;
                end else begin
                    state_d = ST_DRIVE;
                    col_d   = col_q + 2'd1;
                    cnt_d   = SETTLE_LOAD;
                end
            end
            ST_COMMIT: begin
                if (shadow_q == prev_q) begin
                    stable_d = (stable_q >= STB_MAX) ? stable_q : stable_q + STB_W'(1);
                end else begin
                    stable_d = STB_W'(1);
                end
                if (stable_d >= STB_MAX) begin
                    buttons_d = shadow_q;
                end
                prev_d  = shadow_q;
                state_d = ST_IDLE;
                cnt_d   = IDLE_LOAD;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = IDLE_LOAD;
            end
        endcase

        col_n_d = (state_d == ST_DRIVE) ? ~(4'b0001 << col_d) : 4'b1111;
    end

    assign col_n_o    = col_n_q;
    assign buttons    = buttons_q;
    assign frame_done = (state_q == ST_COMMIT);
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_jag_pad_scanner.sv
// Bench for jag_pad_scanner: two instances (debounce 2 and 1) share stimulus and a
// frame-level reference model; a pad model turns the pressed-key matrix into rows.
module tb_jag_pad_scanner;

    localparam int S     = 4;
    localparam int I     = 8;
    localparam int FRAME = 4 * S + 3;

    logic        sys_clk = 1'b0;
    logic        xresetl;
    logic        enable;
    logic [23:0] mat;
    logic [3:0]  col_a, col_b;
    logic [5:0]  row_a, row_b;
    logic [20:0] btn_a, btn_b;
    logic        fd_a, fd_b, busy_a, busy_b;

    int tests = 0;
    int fails = 0;

    bit          m_in_frame;
    int          m_idle_left;
    int          m_pos;
    int          m_stable [2];
    logic [20:0] m_prev   [2];
    logic [20:0] m_btn    [2];
    int          deb      [2] = '{2, 1};

    logic [3:0]  seq_exp [20] = '{4'hE, 4'hE, 4'hE, 4'hE, 4'hF,
                                  4'hD, 4'hD, 4'hD, 4'hD, 4'hF,
                                  4'hB, 4'hB, 4'hB, 4'hB, 4'hF,
                                  4'h7, 4'h7, 4'h7, 4'h7, 4'hF};
    logic [23:0] pool [4];

    always #5 sys_clk = ~sys_clk;

    // Matrix index = column*6 + row, row 0 being pad row 1.
    function automatic logic [5:0] pad(input logic [3:0] col_n, input logic [23:0] m);
        logic [5:0] r;
        r = 6'h3F;
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 6; rr++)
                if (!col_n[c] && m[c*6+rr]) r[rr] = 1'b0;
        return r;
    endfunction

    function automatic logic [20:0] vec(input logic [23:0] m);
        logic [20:0] v;
        int c, r;
        for (int b = 0; b < 21; b++) begin
            if (b < 15) begin
                c = b / 5;
                r = b % 5 + 1;
            end else begin
                c = 3;
                r = b - 15;
            end
            v[b] = m[c*6+r];
        end
        return v;
    endfunction

    assign row_a = pad(col_a, mat);
    assign row_b = pad(col_b, mat);

    jag_pad_scanner #(.SETTLE_CYCLES(S), .IDLE_CYCLES(I), .DEBOUNCE(2)) dut (
        .sys_clk(sys_clk), .xresetl(xresetl), .enable(enable), .col_n_o(col_a),
        .row_n_i(row_a), .buttons(btn_a), .frame_done(fd_a), .busy(busy_a));

    jag_pad_scanner #(.SETTLE_CYCLES(S), .IDLE_CYCLES(I), .DEBOUNCE(1)) dut1 (
        .sys_clk(sys_clk), .xresetl(xresetl), .enable(enable), .col_n_o(col_b),
        .row_n_i(row_b), .buttons(btn_b), .frame_done(fd_b), .busy(busy_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_frame  = 1'b0;
        m_idle_left = I;
        m_pos       = 0;
        for (int k = 0; k < 2; k++) begin
            m_stable[k] = 0;
            m_prev[k]   = '0;
            m_btn[k]    = '0;
        end
    endtask

    task automatic model_commit();
        logic [20:0] sh;
        sh = vec(mat);
        for (int k = 0; k < 2; k++) begin
            if (sh == m_prev[k])
                m_stable[k] = (m_stable[k] + 1 > deb[k]) ? deb[k] : m_stable[k] + 1;
            else
                m_stable[k] = 1;
            if (m_stable[k] >= deb[k]) m_btn[k] = sh;
            m_prev[k] = sh;
        end
    endtask

    // Compare this cycle's outputs, advance the model with the current enable, move to next cycle.
    task automatic tick();
        logic [3:0] ec;
        logic       eb, ef;
        int         c, w;
        if (!m_in_frame) begin
            ec = 4'hF; eb = 1'b0; ef = 1'b0;
        end else if (m_pos == FRAME) begin
            ec = 4'hF; eb = 1'b1; ef = 1'b1;
        end else begin
            c  = m_pos / (S + 1);
            w  = m_pos % (S + 1);
            ec = (w < S) ? ~(4'b0001 << c) : 4'hF;
            eb = 1'b1; ef = 1'b0;
        end
        chk("col_a", col_a, ec);
        chk("col_b", col_b, ec);
        chk("busy_a", busy_a, eb);
        chk("busy_b", busy_b, eb);
        chk("fd_a", fd_a, ef);
        chk("fd_b", fd_b, ef);
        chk("btn_a", btn_a, m_btn[0]);
        chk("btn_b", btn_b, m_btn[1]);
        chk("one_col", {31'b0, ($countones(~col_a) <= 1)}, 32'd1);

        if (!m_in_frame) begin
            if (enable) begin
                if (m_idle_left <= 1) begin
                    m_in_frame = 1'b1;
                    m_pos      = 0;
                end else begin
                    m_idle_left--;
                end
            end
        end else if (m_pos == FRAME) begin
            model_commit();
            m_in_frame  = 1'b0;
            m_idle_left = I;
        end else if (!enable) begin
            m_in_frame  = 1'b0;
            m_idle_left = I;
        end else begin
            m_pos++;
        end
        @(negedge sys_clk);
    endtask

    task automatic wait_drive(output int n);
        n = 0;
        while (col_a == 4'hF && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_col(input logic [3:0] target);
        int n;
        n = 0;
        while (col_a !== target && n < 200) begin
            tick();
            n++;
        end
        chk("wait_col", col_a, target);
    endtask

    task automatic wait_commit();
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            seen = fd_a;
            tick();
            n++;
        end
        chk("commit_seen", seen, 1);
    endtask

    task automatic rst_mid();
        #2 xresetl = 1'b0;
        #1;
        chk("async_col_a", col_a, 4'hF);
        chk("async_col_b", col_b, 4'hF);
        chk("async_busy", busy_a, 0);
        chk("async_fd", fd_a, 0);
        chk("async_btn_a", btn_a, 0);
        chk("async_btn_b", btn_b, 0);
        @(negedge sys_clk);
        xresetl = 1'b1;
        model_reset();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [23:0] base, ghosts;
        xresetl = 1'b0;
        enable  = 1'b0;
        mat     = '0;
        model_reset();
        repeat (2) @(negedge sys_clk);
        chk("rst_col", col_a, 4'hF);
        chk("rst_btn", btn_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_fd", fd_a, 0);

        // Idle pad, full frame sequence.
        xresetl = 1'b1;
        enable  = 1'b1;
        wait_drive(n);
        chk("idle_len", n, 8);
        for (int i = 0; i < 20; i++) begin
            chk("seq_col", col_a, seq_exp[i]);
            chk("seq_fd", fd_a, (i == 19) ? 1 : 0);
            chk("seq_busy", busy_a, 1);
            tick();
        end
        chk("t2_btn", btn_a, 0);
        chk("t2_busy", busy_a, 0);

        // A (col 4 row 2) and 9 (col 1 row 5).
        base = (24'd1 << 19) | (24'd1 << 4);
        mat  = base;
        wait_commit();
        chk("t3_first", btn_a, 0);
        chk("t3_first_d1", btn_b, 21'h010008);
        wait_commit();
        chk("t3_second", btn_a, 21'h010008);

        // Toggle up (col 4 row 6) every frame.
        for (int f = 0; f < 6; f++) begin
            mat = (f % 2 == 0) ? (base | (24'd1 << 23)) : base;
            wait_commit();
            chk("t4_up", btn_a[20], 0);
        end
        chk("t4_btn", btn_a, 21'h010008);

        // Abort during column 3.
        wait_col(4'b1011);
        tick();
        enable = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            chk("t5_fd", fd_a, 0);
            chk("t5_busy", busy_a, 0);
            tick();
        end
        enable = 1'b1;
        wait_drive(n);
        chk("t5_idle_len", n, 8);
        chk("t5_col1", col_a, 4'hE);
        chk("t5_btn", btn_a, 21'h010008);
        wait_commit();
        chk("t5_btn_after", btn_a, 21'h010008);

        // Row 1 pulled on columns 1-3 must not register; then real pause.
        ghosts = (24'd1 << 0) | (24'd1 << 6) | (24'd1 << 12);
        mat = ghosts;
        wait_commit();
        chk("t6_pause_a", btn_a[15], 0);
        chk("t6_ghost_d1", btn_b, 0);
        wait_commit();
        chk("t6_ghost_a", btn_a, 0);
        mat = ghosts | (24'd1 << 18);
        wait_commit();
        chk("t6_pause_d1", btn_b, 21'h008000);
        chk("t6_pause_a_wait", btn_a, 0);

        // Reset in the middle of column 2.
        wait_col(4'b1101);
        tick();
        rst_mid();
        enable = 1'b1;
        wait_drive(n);
        chk("t1_idle_len", n, 8);
        chk("t1_col1", col_a, 4'hE);

        // Randomised traffic.
        for (int k = 0; k < 4; k++) pool[k] = 24'($urandom);
        pool[0] = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (enable ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 9) == 0))
                enable = ~enable;
            if (!m_in_frame && $urandom_range(0, 19) == 0)
                mat = pool[$urandom_range(0, 3)];
            if ($urandom_range(0, 1999) == 0)
                rst_mid();
            else
                tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/jag_pad_scanner.md
Name: jag_pad_scanner

Overview:
- Host-side sequencer for a physical Jaguar joypad connected through the 4-column / 6-row matrix interface.
- Each scan frame drives one column line low at a time (break-before-make) and waits a settle time. It then samples the synchronised row lines and assembles a 21-bit active-high button vector.
- The vector is debounced across frames before publication.
- Sits between the external pad pins and the core's input plumbing. It feeds the same but_* signals the console-side column/row mux consumes.

Parameters:
- SETTLE_CYCLES, 64, cycles a column is held low before sampling; must be >= 3 to cover the synchroniser.
- IDLE_CYCLES, 1024, cycles all columns are released between frames; must be >= 1.
- DEBOUNCE, 2, number of consecutive identical raw frames required before buttons updates; must be >= 1.

Ports:
- sys_clk  in  1  system clock.
- xresetl  in  1  asynchronous active-low reset.
- enable  in  1  scanning allowed when high.
- col_n_o  out  4  column drive to pad, [4:1], active-low.
- row_n_i  in  6  row return from pad, [6:1], active-low, asynchronous to sys_clk.
- buttons  out  21  debounced state, 1 = pressed. Bit assignment:
  - [4:0] = option,3,6,9,hash
  - [9:5] = c,2,5,8,0
  - [14:10] = b,1,4,7,star
  - [20:15] = pause,a,right,left,down,up
- frame_done  out  1  one-cycle pulse at each COMMIT.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (xresetl low, async) forces:
  - col_n_o=4'b1111, buttons=0, frame_done=0, busy=0
  - raw shadow=0, stable counter=0, synchroniser flops=6'b111111
  - state=IDLE with idle counter preloaded to IDLE_CYCLES.
- row_n_i passes through a 2-flop synchroniser; all sampling uses the synchronised value.
- States:
  - IDLE: col_n_o=1111. Counter decrements while enable=1. When it reaches 0 and enable=1, go to DRIVE with column k=1. With enable=0 the counter holds.
  - DRIVE(k): col_n_o has only bit k low. Lasts exactly SETTLE_CYCLES cycles. On the last cycle, the inverted synchronised rows are captured into the shadow slice for column k:
    - k=1..3: rows [6:2] only; row 1 is ignored.
    - k=4: all six rows.
    - Next state is GAP if k<4, else COMMIT.
  - GAP: exactly 1 cycle with col_n_o=1111, then DRIVE(k+1).
  - COMMIT: exactly 1 cycle, col_n_o=1111, frame_done=1.
    - If the shadow equals the previous frame's shadow, stable counter saturating-increments; otherwise it is set to 1.
    - When the post-update count >= DEBOUNCE, buttons <= shadow in the following cycle.
    - Previous-shadow register updates. Next state is IDLE, with the counter reloaded to IDLE_CYCLES.
- Frame length from DRIVE(1) entry to COMMIT inclusive = 4*SETTLE_CYCLES + 3 + 1 cycles.
- Only one col_n_o bit is ever low. No cycle exists where two columns are driven; the GAP cycle guarantees this.
- enable falling mid-frame (DRIVE/GAP):
  - Next cycle goes to IDLE with col_n_o=1111 and the idle counter reloaded.
  - Partial shadow is discarded: no COMMIT, no frame_done, no buttons change, stable counter unchanged.
- enable falling on the COMMIT cycle: COMMIT completes normally.
- DEBOUNCE=1: every COMMIT publishes its shadow.
- Stable counter saturates at DEBOUNCE; it never wraps.
- Async reset mid-frame releases col_n_o immediately, without waiting for a clock edge.

Test Plan:
All scenarios use SETTLE_CYCLES=4, IDLE_CYCLES=8, DEBOUNCE=2 unless stated.

1. Reset mid-DRIVE(2) -> col_n_o=1111 asynchronously; buttons=0; after release, first DRIVE(1) begins 8 enabled cycles later.
2. Pad model (row_n from col_n per the matrix) with no buttons pressed; enable held -> col_n_o sequence is 1110×4, 1111, 1101×4, 1111, 1011×4, 1111, 0111×4, then COMMIT with frame_done=1; busy spans the whole frame; buttons stays 0.
3. Hold "A" and "9" -> buttons = 21'h010008 (bit 15 = a... check: a is bit 16 -> 21'h010008) after the second COMMIT, not the first; frame_done pulses twice.
4. Toggle "up" every frame (pressed/released alternating) -> stable counter never reaches 2; buttons[20] stays 0 across 6 frames.
5. Deassert enable during DRIVE(3), reassert 20 cycles later -> no frame_done for the aborted frame; next frame restarts at column 1 after 8 IDLE cycles; buttons unchanged.
6. Drive row_n_i[1]=0 during columns 1-3 only -> buttons[15] (pause) stays 0. With DEBOUNCE=1 and pause pressed, buttons[15]=1 immediately after the first COMMIT.
